ram_copy_dma: RTL and testbench
===============================

RAM_COPY_DMA -- requirements
Module: ram_copy_dma

Interface
REQ-001 Parameter ADDR_W, default 33, SHALL set the width of every RAM address port.
REQ-002 Parameter DATA_W, default 16, SHALL set the width of every RAM data port.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  request a copy; SHALL be sampled only in IDLE.
REQ-006 src_addr  input  ADDR_W  first source word address; SHALL be captured at start.
REQ-007 dst_addr  input  ADDR_W  first destination word address; SHALL be captured at start.
REQ-008 len  input  16  number of words to copy; SHALL be captured at start.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse at completion, whether the copy succeeded or aborted.
REQ-011 err  output  1  sticky verify-mismatch flag, cleared by the next accepted start.
REQ-012 err_addr  output  ADDR_W  destination address of the first mismatch.
REQ-013 words_done  output  16  count of words written and verified.
REQ-014 ram_wr, ram_wr_addr[ADDR_W], ram_d_in[DATA_W]  outputs  drive the RAM write port.
REQ-015 ram_rd_addr_a, ram_rd_addr_b [ADDR_W]  outputs  drive the RAM read ports.
REQ-016 ram_d_out_a, ram_d_out_b [DATA_W]  inputs  combinational RAM read data.

Function
REQ-017 FSM states: IDLE, READ, WRITE, CHECK, DONE.
REQ-018 Transitions: IDLE -> READ on start with len!=0; IDLE -> DONE on start with len==0; READ -> WRITE; WRITE -> CHECK; CHECK -> READ on a match with words remaining; CHECK -> DONE on a match with the last word; CHECK -> DONE on a mismatch; DONE -> IDLE.
REQ-019 READ: ram_rd_addr_a SHALL equal src+idx, and the data register SHALL capture ram_d_out_a at the end of the cycle.
REQ-020 WRITE: ram_wr=1, ram_wr_addr=dst+idx, ram_d_in=data register; ram_wr SHALL be 0 in every other state.
REQ-021 CHECK: ram_rd_addr_b SHALL equal dst+idx; if ram_d_out_b equals the data register, then idx and words_done SHALL increment.
REQ-022 CHECK mismatch: the block SHALL set err, load err_addr with dst+idx, leave words_done unchanged, and stop the copy.
REQ-023 Latency: a copy of N words with no error SHALL keep busy high for 3N+1 cycles; len=0 SHALL give a 1-cycle DONE with no writes.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_W, so addresses wrap from all-ones to 0 silently.
REQ-025 Words SHALL be copied in ascending index order; no protection against overlapping regions is provided.
REQ-026 start, src_addr, dst_addr and len SHALL be ignored while busy; a start coincident with DONE SHALL be ignored.
REQ-027 Read addresses SHALL hold their last value outside READ and CHECK.

Reset
REQ-028 While reset=0, the block SHALL force state=IDLE, busy=0, done=0, err=0, err_addr=0, words_done=0, ram_wr=0, all RAM addresses to 0, ram_d_in=0, and idx=0.
REQ-029 Asserting reset during any state SHALL abort the copy immediately and drop ram_wr asynchronously, without waiting for a clock edge.
REQ-030 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-031 A shared package ram_pkg SHALL hold ADDR_W, DATA_W and the FSM state encoding.
REQ-032 The block SHALL be a single module with no sub-modules; it connects to ram8b as the initiator on all three ports.

Verification
REQ-033 Preload src 0x100..0x103 = 0xA5A0..0xA5A3, then start with src=0x100, dst=0x200, len=4 -> dst holds the same data, busy high for 13 cycles, done pulses once, err=0, words_done=4.
REQ-034 Start with len=0 -> busy high for 1 cycle, done pulses, ram_wr never asserted.
REQ-035 Force ram_d_out_b to 0xDEAD on word 2 of a len=4 copy with dst=0x200 -> err=1, err_addr=0x202, words_done=2, done pulses after that CHECK.
REQ-036 Start with src=0x1_FFFF_FFFF, dst=0x0_0000_0010, len=2 -> second read from address 0x0, writes to 0x10 and 0x11.
REQ-037 Drive reset=0 during WRITE of a len=8 copy -> ram_wr falls before the next edge, all outputs return to reset values, and a following start runs normally.
REQ-038 Pulse start again while busy with different arguments -> ignored; the original copy completes unchanged.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM-to-RAM copy engine: bus widths and FSM state encoding.
package ram_pkg;

  localparam int ADDR_W = 33;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_copy_dma_if.sv
// Control and RAM-port bundle of the copy engine; master is the engine, slave is its environment.
interface ram_copy_dma_if #(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int LEN_W  = ram_pkg::LEN_W
);

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;
  logic [LEN_W-1:0]  words_done;

  logic              ram_wr;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_d_in;
  logic [ADDR_W-1:0] ram_rd_addr_a;
  logic [ADDR_W-1:0] ram_rd_addr_b;
  logic [DATA_W-1:0] ram_d_out_a;
  logic [DATA_W-1:0] ram_d_out_b;

  modport master (
    input  start, src_addr, dst_addr, len, ram_d_out_a, ram_d_out_b,
    output busy, done, err, err_addr, words_done,
           ram_wr, ram_wr_addr, ram_d_in, ram_rd_addr_a, ram_rd_addr_b
  );

  modport slave (
    output start, src_addr, dst_addr, len, ram_d_out_a, ram_d_out_b,
    input  busy, done, err, err_addr, words_done,
           ram_wr, ram_wr_addr, ram_d_in, ram_rd_addr_a, ram_rd_addr_b
  );

endinterface

// File: rtl/ram_copy_dma.sv
// Copies len words from src to dst one at a time, reading each back after writing it and
// aborting on the first verify mismatch. All outputs are registers.
module ram_copy_dma #(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  ram_copy_dma_if.master bus
);
  import ram_pkg::*;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;
  logic              r_wr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr_a;
  logic [ADDR_W-1:0] r_rd_addr_b;

  logic [LEN_W-1:0]  w_idx_next;
  logic              w_match;
  logic              w_last;

  // Word address base+idx, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] f_offset(input logic [ADDR_W-1:0] base,
                                                 input logic [LEN_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

  assign w_idx_next = r_idx + LEN_W'(1'b1);
  assign w_match    = (bus.ram_d_out_b == r_data);
  assign w_last     = (w_idx_next == r_len);

  // Copy sequencer: one READ/WRITE/CHECK round per word, then a single DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
      r_wr        <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
    end else begin
      r_done <= 1'b0;
      r_wr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_src      <= bus.src_addr;
            r_dst      <= bus.dst_addr;
            r_len      <= bus.len;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_busy     <= 1'b1;
            if (bus.len != '0) begin
              r_state     <= ST_READ;
              r_rd_addr_a <= bus.src_addr;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          r_data    <= bus.ram_d_out_a;
          r_wr      <= 1'b1;
          r_wr_addr <= f_offset(r_dst, r_idx);
          r_state   <= ST_WRITE;
        end
        ST_WRITE: begin
          r_rd_addr_b <= f_offset(r_dst, r_idx);
          r_state     <= ST_CHECK;
        end
        ST_CHECK: begin
          // idx doubles as the verified-word count reported on words_done.
          if (w_match) begin
            r_idx <= w_idx_next;
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_READ;
              r_rd_addr_a <= f_offset(r_src, w_idx_next);
            end
          end else begin
            r_err      <= 1'b1;
            r_err_addr <= r_rd_addr_b;
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign bus.err_addr      = r_err_addr;
  assign bus.words_done    = r_idx;
  assign bus.ram_wr        = r_wr;
  assign bus.ram_wr_addr   = r_wr_addr;
  assign bus.ram_d_in      = r_data;
  assign bus.ram_rd_addr_a = r_rd_addr_a;
  assign bus.ram_rd_addr_b = r_rd_addr_b;

endmodule

// File: tb/tb_ram_copy_dma.sv
// Self-checking bench for ram_copy_dma: behavioural RAM, word-level copy model, directed and random scenarios.
module tb_ram_copy_dma;

  localparam int AW = ram_pkg::ADDR_W;
  localparam int DW = ram_pkg::DATA_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_copy_dma_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // RAM model aliased onto 4K words; test regions never collide in the low 12 bits.
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  logic          pl_we = 1'b0;
  logic [11:0]   pl_addr = 12'd0;
  logic [DW-1:0] pl_data = '0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  always @(posedge clk) begin
    if (bus.ram_wr) mem[bus.ram_wr_addr[11:0]] <= bus.ram_d_in;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end
  assign bus.ram_d_out_a = mem[bus.ram_rd_addr_a[11:0]];
  assign bus.ram_d_out_b = (corrupt_en && bus.ram_rd_addr_b == corrupt_addr) ? 16'hDEAD
                                                                             : mem[bus.ram_rd_addr_b[11:0]];

  int n_pass = 0;
  int n_total = 0;

  // expected results from the model
  logic [AW-1:0] exp_wr_q[$];
  int            exp_busy;
  int            exp_wd;
  logic          exp_err;
  logic [AW-1:0] exp_err_addr;
  // observations from the last run
  logic [AW-1:0] obs_wr_q[$];
  int            obs_busy;
  int            obs_done;
  bit            obs_finished;

  task automatic preload(input logic [AW-1:0] base, input int n, input logic [DW-1:0] first, input bit rnd);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      d = rnd ? DW'($urandom) : first + DW'(i);
      if (d == 16'hDEAD) d = 16'hBEEF;
      @(negedge clk);
      pl_we = 1'b1; pl_addr = a[11:0]; pl_data = d;
      ref_mem[a[11:0]] = d;
    end
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Word-level model: copy ascending, each word written then verified; stop at the bad word.
  task automatic model_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n, input int bad);
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    exp_wr_q.delete();
    exp_err = 1'b0; exp_err_addr = '0; exp_wd = 0;
    for (int i = 0; i < n; i++) begin
      s = src + AW'(i);
      d = dst + AW'(i);
      ref_mem[d[11:0]] = ref_mem[s[11:0]];
      exp_wr_q.push_back(d);
      if (i == bad) begin
        exp_err = 1'b1; exp_err_addr = d;
        break;
      end
      exp_wd++;
    end
    exp_busy = 3 * exp_wr_q.size() + 1;
  endtask

  task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [15:0] n, input bit interfere);
    obs_wr_q.delete(); obs_busy = 0; obs_done = 0; obs_finished = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = src; bus.dst_addr = dst; bus.len = n;
    @(negedge clk);
    bus.start = 1'b0;
    bus.src_addr = AW'({$urandom, $urandom}); bus.dst_addr = AW'({$urandom, $urandom}); bus.len = 16'($urandom);
    for (int c = 0; c < 300; c++) begin
      if (bus.busy) obs_busy++;
      if (bus.done) obs_done++;
      if (bus.ram_wr) obs_wr_q.push_back(bus.ram_wr_addr);
      if (!bus.busy) begin
        obs_finished = 1'b1;
        break;
      end
      if (interfere && c == 2) begin
        bus.start = 1'b1; bus.len = 16'd5; bus.src_addr = 33'h700; bus.dst_addr = 33'h900;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.busy, bus.done, bus.err, bus.ram_wr} !== 4'b0000) $display("FAIL reset_flags busy/done/err/wr=%b required 0000", {bus.busy, bus.done, bus.err, bus.ram_wr});
    else n_pass++;
    n_total++;
    if ((bus.err_addr | bus.ram_wr_addr | bus.ram_rd_addr_a | bus.ram_rd_addr_b) !== '0 || bus.words_done !== 16'd0 || bus.ram_d_in !== '0)
      $display("FAIL reset_values err_addr=%h wr_addr=%h rd_a=%h rd_b=%h wd=%0d d_in=%h required all 0",
               bus.err_addr, bus.ram_wr_addr, bus.ram_rd_addr_a, bus.ram_rd_addr_b, bus.words_done, bus.ram_d_in);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_basic;
    preload(33'h100, 4, 16'hA5A0, 1'b0);
    model_copy(33'h100, 33'h200, 4, -1);
    run_copy(33'h100, 33'h200, 16'd4, 1'b0);
    n_total++;
    if (!obs_finished || obs_busy !== 13) $display("FAIL basic_busy_cycles got %0d required 13", obs_busy);
    else n_pass++;
    n_total++;
    if (obs_done !== 1) $display("FAIL basic_done_pulses got %0d required 1", obs_done);
    else n_pass++;
    n_total++;
    if (bus.err !== 1'b0 || bus.words_done !== 16'd4) $display("FAIL basic_status err=%b wd=%0d required err=0 wd=4", bus.err, bus.words_done);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (mem[12'h200 + 12'(i)] !== 16'hA5A0 + 16'(i)) $display("FAIL basic_dst_word%0d got %h required %h", i, mem[12'h200 + 12'(i)], 16'hA5A0 + 16'(i));
      else n_pass++;
    end
  endtask

  task automatic test_mismatch;
    preload(33'h100, 4, 16'hA5A0, 1'b0);
    corrupt_en = 1'b1; corrupt_addr = 33'h202;
    model_copy(33'h100, 33'h200, 4, 2);
    run_copy(33'h100, 33'h200, 16'd4, 1'b0);
    corrupt_en = 1'b0;
    n_total++;
    if (bus.err !== 1'b1 || bus.err_addr !== 33'h202) $display("FAIL mismatch_err err=%b err_addr=%h required 1 / 202", bus.err, bus.err_addr);
    else n_pass++;
    n_total++;
    if (bus.words_done !== 16'd2) $display("FAIL mismatch_words_done got %0d required 2", bus.words_done);
    else n_pass++;
    n_total++;
    if (!obs_finished || obs_busy !== exp_busy || obs_done !== 1 || obs_wr_q.size() !== 3)
      $display("FAIL mismatch_timing busy=%0d done=%0d writes=%0d required %0d/1/3", obs_busy, obs_done, obs_wr_q.size(), exp_busy);
    else n_pass++;
  endtask

  task automatic test_zero_len;
    model_copy(33'h300, 33'h380, 0, -1);
    run_copy(33'h300, 33'h380, 16'd0, 1'b0);
    n_total++;
    if (!obs_finished || obs_busy !== 1 || obs_done !== 1) $display("FAIL zero_len_timing busy=%0d done=%0d required 1/1", obs_busy, obs_done);
    else n_pass++;
    n_total++;
    if (obs_wr_q.size() !== 0 || bus.err !== 1'b0 || bus.words_done !== 16'd0)
      $display("FAIL zero_len_status writes=%0d err=%b wd=%0d required 0/0/0", obs_wr_q.size(), bus.err, bus.words_done);
    else n_pass++;
  endtask

  task automatic test_wrap;
    preload(33'h1_FFFF_FFFF, 1, 16'h1234, 1'b0);
    preload(33'h0, 1, 16'h5678, 1'b0);
    model_copy(33'h1_FFFF_FFFF, 33'h10, 2, -1);
    run_copy(33'h1_FFFF_FFFF, 33'h10, 16'd2, 1'b0);
    n_total++;
    if (obs_wr_q.size() !== 2 || obs_wr_q[0] !== 33'h10 || obs_wr_q[1] !== 33'h11)
      $display("FAIL wrap_write_addrs count=%0d required writes to 10,11", obs_wr_q.size());
    else n_pass++;
    n_total++;
    if (mem[12'h010] !== 16'h1234 || mem[12'h011] !== 16'h5678)
      $display("FAIL wrap_data got %h %h required 1234 5678", mem[12'h010], mem[12'h011]);
    else n_pass++;
    n_total++;
    if (bus.err !== 1'b0 || bus.words_done !== 16'd2 || obs_busy !== 7) $display("FAIL wrap_status err=%b wd=%0d busy=%0d required 0/2/7", bus.err, bus.words_done, obs_busy);
    else n_pass++;
  endtask

  task automatic test_ignore_busy;
    int bad_q;
    preload(33'h500, 4, 16'h0, 1'b1);
    model_copy(33'h500, 33'h580, 4, -1);
    run_copy(33'h500, 33'h580, 16'd4, 1'b1);
    bad_q = (obs_wr_q.size() != exp_wr_q.size()) ? 1 : 0;
    foreach (exp_wr_q[i]) if (bad_q == 0 && obs_wr_q[i] !== exp_wr_q[i]) bad_q++;
    n_total++;
    if (bad_q != 0 || obs_busy !== exp_busy || bus.words_done !== 16'd4)
      $display("FAIL ignore_busy writes=%0d busy=%0d wd=%0d required %0d/%0d/4", obs_wr_q.size(), obs_busy, bus.words_done, exp_wr_q.size(), exp_busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit seen_wr = 1'b0;
    preload(33'h300, 8, 16'h0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = 33'h300; bus.dst_addr = 33'h600; bus.len = 16'd8;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.ram_wr) begin
        seen_wr = 1'b1;
        break;
      end
    end
    n_total++;
    if (!seen_wr) $display("FAIL reset_mid_reach_write ram_wr=%b required 1 within 50 cycles", bus.ram_wr);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (bus.ram_wr !== 1'b0) $display("FAIL reset_mid_async_wr got %b required 0", bus.ram_wr);
    else n_pass++;
    n_total++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.words_done !== 16'd0 || (bus.ram_wr_addr | bus.ram_rd_addr_a | bus.ram_rd_addr_b | bus.err_addr) !== '0 || bus.ram_d_in !== '0)
      $display("FAIL reset_mid_outputs busy=%b done=%b err=%b wd=%0d wr_addr=%h rd_a=%h required all 0",
               bus.busy, bus.done, bus.err, bus.words_done, bus.ram_wr_addr, bus.ram_rd_addr_a);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    preload(33'h340, 3, 16'h0, 1'b1);
    model_copy(33'h340, 33'h640, 3, -1);
    run_copy(33'h340, 33'h640, 16'd3, 1'b0);
    n_total++;
    if (!obs_finished || obs_busy !== 10 || bus.words_done !== 16'd3 || mem[12'h642] !== ref_mem[12'h342])
      $display("FAIL reset_mid_recover busy=%0d wd=%0d last=%h required 10/3/%h", obs_busy, bus.words_done, mem[12'h642], ref_mem[12'h342]);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    int n;
    int bad;
    int bad_words;
    for (int it = 0; it < 8; it++) begin
      n   = $urandom_range(1, 12);
      src = {21'($urandom), 12'h400 + 12'($urandom_range(0, 240))};
      dst = {21'($urandom), 12'hA00 + 12'($urandom_range(0, 240))};
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      preload(src, n, 16'h0, 1'b1);
      corrupt_en = (bad >= 0); corrupt_addr = dst + AW'(bad);
      model_copy(src, dst, n, bad);
      run_copy(src, dst, 16'(n), 1'b0);
      corrupt_en = 1'b0;
      bad_words = (obs_wr_q.size() != exp_wr_q.size()) ? 1 : 0;
      foreach (exp_wr_q[i]) begin
        if (bad_words == 0 && obs_wr_q[i] !== exp_wr_q[i]) bad_words++;
        if (mem[exp_wr_q[i][11:0]] !== ref_mem[exp_wr_q[i][11:0]]) bad_words++;
      end
      n_total++;
      if (bad_words != 0) $display("FAIL random%0d_data %0d bad writes/words (n=%0d)", it, bad_words, n);
      else n_pass++;
      n_total++;
      if (!obs_finished || obs_busy !== exp_busy || obs_done !== 1) $display("FAIL random%0d_timing busy=%0d done=%0d required %0d/1", it, obs_busy, obs_done, exp_busy);
      else n_pass++;
      n_total++;
      if (bus.err !== exp_err || bus.words_done !== 16'(exp_wd) || (exp_err && bus.err_addr !== exp_err_addr))
        $display("FAIL random%0d_status err=%b wd=%0d err_addr=%h required %b/%0d/%h", it, bus.err, bus.words_done, bus.err_addr, exp_err, exp_wd, exp_err_addr);
      else n_pass++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    test_reset;
    test_basic;
    test_mismatch;
    test_zero_len;
    test_wrap;
    test_ignore_busy;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
